// File: rtl/id_ex_skid_reg.sv
// ============================================================================
// Module  : id_ex_skid_reg
// Purpose : ID->EX pipeline register with a 2-entry skid buffer, flush and a
//           saturating stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int              c_pay_w   = 4 * DATA_W + 5 + CTRL_W;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [c_pay_w-1:0] r_main;
    logic [c_pay_w-1:0] r_skid;
    logic               r_main_valid;
    logic               r_skid_valid;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [c_pay_w-1:0] w_in;
    logic               w_accept;
    logic               w_drain;

    assign w_in     = {id_pc, id_rs_data, id_rt_data, id_imm_ext, id_rd, id_ctrl};
    // id_ready depends only on a flop, keeping ex_ready off the upstream timing path.
    assign id_ready = ~r_skid_valid;
    assign w_accept = id_valid & ~r_skid_valid;
    assign w_drain  = r_main_valid & ex_ready;

    assign ex_valid = r_main_valid;
    assign {ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rd, ex_ctrl} = r_main;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            // Counter keeps running across flushes; it measures back-pressure only.
            if (r_main_valid && !ex_ready && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_main_valid || w_drain) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main       <= w_in;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid       <= w_in;
                r_skid_valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
